prbs_checker: RTL

- Receive-side companion of the variable-length PRBS generator. It consumes the serial PRBS bit stream, self-synchronises to it, locks, and then counts bit errors.
- It sits at the far end of the link or in loopback, fed one bit per Dato_Valido strobe.
- Polynomial set and Longitud encoding are identical to the generator's, so the same Longitud value drives both ends.

---
 rtl/prbs_pkg.sv | 21 ++
 rtl/prbs_tap_mux.sv | 33 +++
 rtl/prbs_checker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: Longitud encodings, tap tables and the checker state encoding.
// Used by both the PRBS generator and prbs_checker.
package prbs_pkg;

    // Longitud encodings, identical at both ends of the link
    localparam logic [1:0] LONG_30 = 2'b00;
    localparam logic [1:0] LONG_25 = 2'b01;
    localparam logic [1:0] LONG_20 = 2'b10;
    localparam logic [1:0] LONG_6  = 2'b11;

    // Tap pair (A,B) for each Longitud; the sequence is x[n] = x[n-A] ^ x[n-B]
    localparam int unsigned TAP_A [4] = '{30, 25, 20, 6};
    localparam int unsigned TAP_B [4] = '{20, 15, 10, 4};

    typedef enum logic [1:0] {
        BUSCAR = 2'd0,
        SEGUIR = 2'd1,
        BLOQ   = 2'd2
    } prbs_state_e;

endpackage

// File: rtl/prbs_tap_mux.sv
// Combinational tap select: from Longitud and the 30-bit history (r[0] newest), produces the
// predicted next bit, the register length A and a mask covering r[A-1:0].
module prbs_tap_mux
    import prbs_pkg::*;
(
    input  logic [1:0]  longitud_i,
    input  logic [29:0] r_i,
    output logic        p_o,
    output logic [4:0]  len_o,
    output logic [29:0] mask_o
);

    logic [4:0] tap_a;
    logic [4:0] tap_b;

    // Decode the tap pair for the selected polynomial
    always_comb begin
        tap_a = 5'(TAP_A[0]);
        tap_b = 5'(TAP_B[0]);
        unique case (longitud_i)
            LONG_30: begin tap_a = 5'(TAP_A[0]); tap_b = 5'(TAP_B[0]); end
            LONG_25: begin tap_a = 5'(TAP_A[1]); tap_b = 5'(TAP_B[1]); end
            LONG_20: begin tap_a = 5'(TAP_A[2]); tap_b = 5'(TAP_B[2]); end
            LONG_6:  begin tap_a = 5'(TAP_A[3]); tap_b = 5'(TAP_B[3]); end
        endcase
    end

    assign p_o   = r_i[tap_a - 5'd1] ^ r_i[tap_b - 5'd1];
    assign len_o = tap_a;
    // For A = 30 the shift wraps to zero and the subtraction yields all ones
    assign mask_o = (30'd1 << tap_a) - 30'd1;

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to the serial stream (BUSCAR -> SEGUIR),
// declares lock after LOCK_COUNT good predictions (BLOQ) and then counts bit errors in
// flywheel mode. Lock is dropped after LOSS_THRESH errors within a WIN_LEN-bit window.
// Optional macro PRBS_CHK_BITCNT_EN adds Bits_Verificados, the count of bits checked in BLOQ.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 32,
    parameter int unsigned WIN_LEN     = 64,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [1:0]           Longitud,
    input  logic                 Dato_In,
    input  logic                 Dato_Valido,
    input  logic                 Borrar_Cnt,
    output logic                 Bloqueado,
    output logic                 Error_Bit,
    output logic [ERR_CNT_W-1:0] Contador_Errores
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]          Bits_Verificados
`endif
);

    localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WinW   = $clog2(WIN_LEN + 1);
    localparam int unsigned WerrW  = $clog2(LOSS_THRESH + 1);

    prbs_state_e          state_q, state_d;
    logic [29:0]          r_q, r_d;
    logic [4:0]           fill_q, fill_d;
    logic [MatchW-1:0]    match_q, match_d;
    logic [WinW-1:0]      win_q, win_d;
    logic [WerrW-1:0]     werr_q, werr_d;
    logic                 bloq_q, bloq_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]           long_q;

    logic                 p;
    logic [4:0]           len_a;
    logic [29:0]          mask;
    logic [29:0]          r_shift;
    logic                 mism;
    logic                 long_chg;
    logic [4:0]           fill_inc;
    logic [MatchW-1:0]    match_inc;
    logic [WinW-1:0]      win_inc;
    logic [WerrW-1:0]     werr_inc;

    prbs_tap_mux u_tap_mux (
        .longitud_i (Longitud),
        .r_i        (r_q),
        .p_o        (p),
        .len_o      (len_a),
        .mask_o     (mask)
    );

    assign r_shift   = {r_q[28:0], Dato_In};
    assign mism      = Dato_In ^ p;
    assign long_chg  = (Longitud != long_q);
    assign fill_inc  = fill_q + 5'd1;
    assign match_inc = match_q + MatchW'(1);
    assign win_inc   = win_q + WinW'(1);
    assign werr_inc  = werr_q + WerrW'(mism);

    // Next-state: sync search, prediction tracking, flywheel error counting
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        bloq_d  = bloq_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (long_chg) begin
            // Polynomial changed: resynchronise from scratch, the current bit is dropped
            state_d = BUSCAR;
            bloq_d  = 1'b0;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
        end else if (Dato_Valido) begin
            unique case (state_q)
                BUSCAR: begin
                    r_d = r_shift;
                    if (fill_inc == len_a) begin
                        fill_d = '0;
                        // An all-zero history would predict zeros forever; keep filling
                        if ((r_shift & mask) != '0) begin
                            state_d = SEGUIR;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_inc;
                    end
                end
                SEGUIR: begin
                    r_d     = r_shift;
                    match_d = mism ? '0 : match_inc;
                    if ((r_shift & mask) == '0) begin
                        state_d = BUSCAR;
                        fill_d  = '0;
                        match_d = '0;
                    end else if (!mism && (match_inc == MatchW'(LOCK_COUNT))) begin
                        state_d = BLOQ;
                        bloq_d  = 1'b1;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
                BLOQ: begin
                    // Flywheel: history follows the prediction so each channel error counts once
                    r_d   = {r_q[28:0], p};
                    err_d = mism;
                    if (mism && (cnt_q != '1)) begin
                        cnt_d = cnt_q + ERR_CNT_W'(1);
                    end
                    if (werr_inc >= WerrW'(LOSS_THRESH)) begin
                        state_d = BUSCAR;
                        bloq_d  = 1'b0;
                        r_d     = '0;
                        fill_d  = '0;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_inc == WinW'(WIN_LEN)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_inc;
                        werr_d = werr_inc;
                    end
                end
                default: state_d = BUSCAR;
            endcase
        end
        // Clear wins over a simultaneous increment
        if (Borrar_Cnt) begin
            cnt_d = '0;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge Clk) begin
        // Tracks Longitud even in reset so the first post-reset cycle sees no change
        long_q <= Longitud;
        if (Reset) begin
            state_q <= BUSCAR;
            r_q     <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            bloq_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            bloq_q  <= bloq_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Bloqueado        = bloq_q;
    assign Error_Bit        = err_q;
    assign Contador_Errores = cnt_q;

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bits_q, bits_d;

    // Saturating count of bits compared while locked
    always_comb begin
        bits_d = bits_q;
        if (Borrar_Cnt) begin
            bits_d = '0;
        end else if (!long_chg && Dato_Valido && (state_q == BLOQ) && (bits_q != '1)) begin
            bits_d = bits_q + 32'd1;
        end
    end

    // Bit-count register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign Bits_Verificados = bits_q;
`endif

endmodule
